// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Contents: NOP instruction encoding, fetch FSM state type, fetch-buffer entry layout.
// Imported by fetch_fifo and fetch_ctrl.
package fetch_pkg;

   // addi x0, x0, 0 -- placed in fault entries so decode sees a harmless instruction
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched entries; flush beats push and pop; push allowed when full if popping.
// Ports: clk/reset, flush_i/push_i/pop_i controls, wdata_i entry in, head_o registered head entry,
//        full_o/empty_o/count_o occupancy. head_o holds its last value while empty (zero after reset).
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type T = fetch_entry_t,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  T              wdata_i,
   output T              head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   T              head_q, head_d;
   logic          push_eff;
   logic          pop_eff;

   always_comb begin
      pop_eff  = pop_i && (cnt_q != '0);
      push_eff = push_i && ((cnt_q != CW'(DEPTH)) || pop_eff);
      rd_d     = rd_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      head_d   = head_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (pop_eff)  rd_d = rd_q + AW'(1);
         if (push_eff) wr_d = wr_q + AW'(1);
         cnt_d = cnt_q + CW'(push_eff) - CW'(pop_eff);
         // The head is kept in its own register so it is valid the cycle after a push into an
         // empty (or draining) buffer; the new word bypasses storage when it lands at the head.
         if (cnt_d != '0) begin
            head_d = (push_eff && (rd_d == wr_q)) ? wdata_i : mem_q[rd_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!flush_i && push_eff) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   assign head_o  = head_q;
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, reads the combinational imem, buffers words for decode.
// Ports: clk/reset, fetch_en, imem_addr/imem_rdata, redirect_valid/redirect_pc,
//        if_valid/if_ready handshake with if_instr/if_pc/if_fault head entry.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   // Low bits of a misaligned redirect target; nonzero means the next RUN push is a fault entry.
   logic [1:0]    mis_q, mis_d;

   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          out_of_range;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_WORDS);
   // A redirect flushes the buffer, so a concurrent handshake must not count as consumed.
   assign pop          = !empty && if_ready && !redirect_valid;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mis_d      = mis_q;
      push       = 1'b0;
      push_entry = '{pc: pc_q, instr: imem_rdata, fault: 1'b0};
      if (redirect_valid) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         mis_d   = redirect_pc[1:0];
         state_d = fetch_en ? RUN : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (fetch_en) state_d = RUN;
            end
            RUN: begin
               if (!fetch_en) begin
                  state_d = IDLE;
               end else if (!full || pop) begin
                  push = 1'b1;
                  if (mis_q != 2'b00) begin
                     // Report the original unaligned target, not the aligned PC register.
                     push_entry = '{pc: {pc_q[31:2], mis_q}, instr: NOP_INSTR, fault: 1'b1};
                     mis_d      = 2'b00;
                     state_d    = FAULT;
                  end else if (out_of_range) begin
                     push_entry = '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};
                     state_d    = FAULT;
                  end else begin
                     pc_d = pc_q + 32'd4;
                  end
               end
            end
            FAULT: begin
               // Parked with PC held until a redirect arrives.
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         mis_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign imem_addr = pc_q;
   assign if_valid  = (count != '0);
   assign if_instr  = head.instr;
   assign if_pc     = head.pc;
   assign if_fault  = head.fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   logic [31:0] imem [0:63];
   int          vectors;
   int          miscompares;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2),
      .IMEM_WORDS (64)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_fault       (if_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = (imem_addr[31:8] == 24'd0) ? imem[imem_addr[7:2]] : 32'h0;

   // Reset for two cycles with the given handshake settings, release at a negedge.
   task automatic do_reset(input logic en, input logic rdy);
      @(negedge clk);
      reset          = 1'b1;
      fetch_en       = en;
      if_ready       = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset          = 1'b1;
      fetch_en       = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({if_valid, if_instr, if_pc, if_fault} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got v=%b i=%h pc=%h f=%b want all zero", if_valid, if_instr, if_pc, if_fault);
      end
      vectors++;
      if (imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_imem_addr got %h want 00000000", imem_addr);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream;
      logic [31:0] exp_instr [3];
      int n;
      exp_instr[0] = 32'h0050_0093;
      exp_instr[1] = 32'h0000_0113;
      exp_instr[2] = 32'h0010_0113;
      n = 0;
      while (!if_valid && n < 4) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'(4 * k), exp_instr[k], 1'b0}) begin
            miscompares++;
            $display("FAIL stream_%0d got v=%b pc=%h i=%h f=%b want v=1 pc=%h i=%h f=0",
                     k, if_valid, if_pc, if_instr, if_fault, 32'(4 * k), exp_instr[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stall;
      logic [31:0] exp_instr [3];
      exp_instr[0] = 32'h0050_0093;
      exp_instr[1] = 32'h0000_0113;
      exp_instr[2] = 32'h0010_0113;
      do_reset(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      vectors++;
      if (imem_addr !== 32'h8) begin
         miscompares++;
         $display("FAIL stall_imem_addr got %h want 00000008", imem_addr);
      end
      vectors++;
      if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL stall_head got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc);
      end
      if_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * k), exp_instr[k]}) begin
            miscompares++;
            $display("FAIL stall_drain_%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                     k, if_valid, if_pc, if_instr, 32'(4 * k), exp_instr[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_full;
      do_reset(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8;
      if_ready       = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      vectors++;
      if (if_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_flush got v=%b want 0", if_valid);
      end
      @(negedge clk);
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 32'h0010_0113}) begin
         miscompares++;
         $display("FAIL redir_first got v=%b pc=%h i=%h want v=1 pc=00000008 i=00100113", if_valid, if_pc, if_instr);
      end
      @(negedge clk);
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, 32'hFE20_9EE3}) begin
         miscompares++;
         $display("FAIL redir_second got v=%b pc=%h i=%h want v=1 pc=0000000c i=fe209ee3", if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_range_fault;
      logic [31:0] exp_pc [3];
      logic [31:0] exp_instr [3];
      logic        exp_fault [3];
      exp_pc[0] = 32'hF8;  exp_instr[0] = 32'h0; exp_fault[0] = 1'b0;
      exp_pc[1] = 32'hFC;  exp_instr[1] = 32'h0; exp_fault[1] = 1'b0;
      exp_pc[2] = 32'h100; exp_instr[2] = NOP;   exp_fault[2] = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hF8;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, exp_pc[k], exp_instr[k], exp_fault[k]}) begin
            miscompares++;
            $display("FAIL range_%0d got v=%b pc=%h i=%h f=%b want v=1 pc=%h i=%h f=%b",
                     k, if_valid, if_pc, if_instr, if_fault, exp_pc[k], exp_instr[k], exp_fault[k]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if ({if_valid, imem_addr} !== {1'b0, 32'h100}) begin
            miscompares++;
            $display("FAIL range_parked_%0d got v=%b addr=%h want v=0 addr=00000100", k, if_valid, imem_addr);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'h0, 32'h0050_0093, 1'b0}) begin
         miscompares++;
         $display("FAIL range_resume got v=%b pc=%h i=%h f=%b want v=1 pc=00000000 i=00500093 f=0",
                  if_valid, if_pc, if_instr, if_fault);
      end
   endtask

   task automatic test_misalign;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h6;
      @(negedge clk);
      redirect_valid = 1'b0;
      vectors++;
      if (if_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign_flush got v=%b want 0", if_valid);
      end
      @(negedge clk);
      vectors++;
      if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, 32'h6, NOP, 1'b1}) begin
         miscompares++;
         $display("FAIL misalign_entry got v=%b pc=%h i=%h f=%b want v=1 pc=00000006 i=00000013 f=1",
                  if_valid, if_pc, if_instr, if_fault);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({if_valid, imem_addr} !== {1'b0, 32'h4}) begin
            miscompares++;
            $display("FAIL misalign_parked_%0d got v=%b addr=%h want v=0 addr=00000004", k, if_valid, imem_addr);
         end
      end
   endtask

   task automatic test_reset_mid;
      do_reset(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      vectors++;
      if (if_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre got v=%b want 1", if_valid);
      end
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      fetch_en       = 1'b0;
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      vectors++;
      if ({if_valid, imem_addr} !== {1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL rstmid_after got v=%b addr=%h want v=0 addr=00000000", if_valid, imem_addr);
      end
      if_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         vectors++;
         if ({if_valid, imem_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid_idle_%0d got v=%b addr=%h want v=0 addr=00000000", k, if_valid, imem_addr);
         end
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      reset          = 1'b1;
      fetch_en       = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
      imem[0] = 32'h0050_0093;
      imem[1] = 32'h0000_0113;
      imem[2] = 32'h0010_0113;
      imem[3] = 32'hFE20_9EE3;
      imem[4] = 32'h0010_0013;

      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_range_fault();
      test_misalign();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
